// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// The FSM state and owner encodings live here so benches and RTL agree on them.
package riscv_pkg;

    localparam int XLEN             = 32;
    localparam int ARB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

endpackage : riscv_pkg

// File: rtl/mem_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and load/store.
// Load/store has priority; a saturating counter forces a fetch grant after STARVE_LIMIT back-to-back ls grants.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic            clk_i,
    input  logic            rstn_i,

    input  logic            if_req_valid_i,
    output logic            if_req_ready_o,
    input  logic [XLEN-1:0] if_req_addr_i,
    output logic            if_rsp_valid_o,
    output logic [XLEN-1:0] if_rsp_data_o,

    input  logic            ls_req_valid_i,
    output logic            ls_req_ready_o,
    input  logic [XLEN-1:0] ls_req_addr_i,
    input  logic            ls_req_we_i,
    input  logic [XLEN-1:0] ls_req_wdata_i,
    input  logic [3:0]      ls_req_be_i,
    output logic            ls_rsp_valid_o,
    output logic [XLEN-1:0] ls_rsp_data_o,

    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    output logic            mem_req_we_o,
    output logic [XLEN-1:0] mem_req_wdata_o,
    output logic [3:0]      mem_req_be_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rsp_data_i
);

    localparam int                CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              if_rsp_valid_q, if_rsp_valid_d;
    logic              ls_rsp_valid_q, ls_rsp_valid_d;
    logic [XLEN-1:0]   if_rsp_data_q, if_rsp_data_d;
    logic [XLEN-1:0]   ls_rsp_data_q, ls_rsp_data_d;

    logic idle;
    logic fetch_wins;
    logic if_grant;
    logic ls_grant;

    // Arbitration is resolved in the same IDLE cycle the requests are seen.
    always_comb begin
        idle       = (state_q == IDLE);
        fetch_wins = if_req_valid_i && (!ls_req_valid_i || (starve_q == STARVE_MAX));
        if_grant   = idle && fetch_wins;
        ls_grant   = idle && ls_req_valid_i && !fetch_wins;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
        state_d        = state_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        if_rsp_valid_d = 1'b0;
        ls_rsp_valid_d = 1'b0;
        if_rsp_data_d  = if_rsp_data_q;
        ls_rsp_data_d  = ls_rsp_data_q;

        case (state_q)
            IDLE: begin
                if (if_grant) begin
                    state_d = ISSUE;
                    owner_d = OWN_IF;
                    addr_d  = {if_req_addr_i[XLEN-1:2], 2'b00};
                    we_d    = 1'b0;
                    wdata_d = '0;
                    be_d    = 4'hF;
                end else if (ls_grant) begin
                    state_d = ISSUE;
                    owner_d = OWN_LS;
                    addr_d  = ls_req_addr_i;
                    we_d    = ls_req_we_i;
                    wdata_d = ls_req_wdata_i;
                    be_d    = ls_req_be_i;
                end
            end
            ISSUE: begin
                // A response seen here belongs to nothing and is dropped.
                if (mem_req_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid_i) begin
                    state_d = IDLE;
                    if (owner_q == OWN_IF) begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_data_d  = we_q ? '0 : mem_rsp_data_i;
                    end else begin
                        ls_rsp_valid_d = 1'b1;
                        ls_rsp_data_d  = we_q ? '0 : mem_rsp_data_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Starvation counter only moves in IDLE; a quiet fetch side resets it.
    always_comb begin
        starve_d = starve_q;
        if (idle) begin
            if (if_grant || !if_req_valid_i) begin
                starve_d = '0;
            end else if (ls_grant && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= IDLE;
            owner_q        <= OWN_IF;
            starve_q       <= '0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            be_q           <= '0;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            ls_rsp_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
            state_q        <= state_d;
            owner_q        <= owner_d;
            starve_q       <= starve_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            ls_rsp_data_q  <= ls_rsp_data_d;
        end
    end

    assign if_req_ready_o  = if_grant;
    assign ls_req_ready_o  = ls_grant;
    assign if_rsp_valid_o  = if_rsp_valid_q;
    assign if_rsp_data_o   = if_rsp_data_q;
    assign ls_rsp_valid_o  = ls_rsp_valid_q;
    assign ls_rsp_data_o   = ls_rsp_data_q;
    assign mem_req_valid_o = (state_q == ISSUE);
    assign mem_req_addr_o  = addr_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_wdata_o = wdata_q;
    assign mem_req_be_o    = be_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a response scoreboard is filled at each grant
// and drained by a monitor whenever either rsp_valid_o pulses.
module tb_mem_arbiter;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        if_req_valid_i, if_req_ready_o, if_rsp_valid_o;
    logic [31:0] if_req_addr_i, if_rsp_data_o;
    logic        ls_req_valid_i, ls_req_ready_o, ls_req_we_i, ls_rsp_valid_o;
    logic [31:0] ls_req_addr_i, ls_req_wdata_i, ls_rsp_data_o;
    logic [3:0]  ls_req_be_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_req_we_o, mem_rsp_valid_i;
    logic [31:0] mem_req_addr_o, mem_req_wdata_o, mem_rsp_data_i;
    logic [3:0]  mem_req_be_o;

    typedef struct {
        arb_owner_e  owner;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .if_req_valid_i  (if_req_valid_i),
        .if_req_ready_o  (if_req_ready_o),
        .if_req_addr_i   (if_req_addr_i),
        .if_rsp_valid_o  (if_rsp_valid_o),
        .if_rsp_data_o   (if_rsp_data_o),
        .ls_req_valid_i  (ls_req_valid_i),
        .ls_req_ready_o  (ls_req_ready_o),
        .ls_req_addr_i   (ls_req_addr_i),
        .ls_req_we_i     (ls_req_we_i),
        .ls_req_wdata_i  (ls_req_wdata_i),
        .ls_req_be_i     (ls_req_be_i),
        .ls_rsp_valid_o  (ls_rsp_valid_o),
        .ls_rsp_data_o   (ls_rsp_data_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_we_o    (mem_req_we_o),
        .mem_req_wdata_o (mem_req_wdata_o),
        .mem_req_be_o    (mem_req_be_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic push(input arb_owner_e owner, input logic [31:0] data);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        sb.push_back(e);
    endtask

    // Entered at the negedge where ISSUE is visible; returns at the negedge where the response is visible.
    task automatic serve(input logic [31:0] exp_addr, input logic exp_we, input logic [31:0] rdata);
        check("issue_valid", {31'd0, mem_req_valid_o}, 32'd1);
        check("issue_addr", mem_req_addr_o, exp_addr);
        check("issue_we", {31'd0, mem_req_we_o}, {31'd0, exp_we});
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        check("wait_valid", {31'd0, mem_req_valid_o}, 32'd0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = rdata;
        tick();
        mem_rsp_valid_i = 1'b0;
    endtask

    // Scoreboard monitor: any response pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rstn_i && (if_rsp_valid_o || ls_rsp_valid_o)) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", {30'd0, if_rsp_valid_o, ls_rsp_valid_o}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_if_valid", {31'd0, if_rsp_valid_o}, {31'd0, e.owner == OWN_IF});
                check("rsp_ls_valid", {31'd0, ls_rsp_valid_o}, {31'd0, e.owner == OWN_LS});
                check("rsp_data", (e.owner == OWN_IF) ? if_rsp_data_o : ls_rsp_data_o, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i          = 1'b0;
        if_req_valid_i  = 1'b0;
        if_req_addr_i   = '0;
        ls_req_valid_i  = 1'b0;
        ls_req_addr_i   = '0;
        ls_req_we_i     = 1'b0;
        ls_req_wdata_i  = '0;
        ls_req_be_i     = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;

        // Reset state
        tick();
        check("rst_mem_valid", {31'd0, mem_req_valid_o}, 32'd0);
        check("rst_mem_addr", mem_req_addr_o, 32'd0);
        check("rst_mem_be", {28'd0, mem_req_be_o}, 32'd0);
        check("rst_rsp_valid", {30'd0, if_rsp_valid_o, ls_rsp_valid_o}, 32'd0);
        tick();
        rstn_i = 1'b1;
        tick();

        // Fetch only, misaligned address gets word-aligned
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h0000_0106;
        #1;
        check("s1_if_ready", {31'd0, if_req_ready_o}, 32'd1);
        check("s1_ls_ready", {31'd0, ls_req_ready_o}, 32'd0);
        push(OWN_IF, 32'hDEAD_BEEF);
        tick();
        if_req_valid_i = 1'b0;
        check("s1_be", {28'd0, mem_req_be_o}, 32'hF);
        serve(32'h0000_0104, 1'b0, 32'hDEAD_BEEF);
        check("s1_pulse", {31'd0, if_rsp_valid_o}, 32'd1);
        check("s1_ls_quiet", {31'd0, ls_rsp_valid_o}, 32'd0);
        tick();
        check("s1_pulse_end", {31'd0, if_rsp_valid_o}, 32'd0);

        // Fetch and store raised together: store first, then fetch
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h0000_0010;
        ls_req_valid_i = 1'b1;
        ls_req_we_i    = 1'b1;
        ls_req_addr_i  = 32'h0000_0040;
        ls_req_wdata_i = 32'h1234_5678;
        ls_req_be_i    = 4'b0011;
        #1;
        check("s2_ls_ready", {31'd0, ls_req_ready_o}, 32'd1);
        check("s2_if_ready", {31'd0, if_req_ready_o}, 32'd0);
        push(OWN_LS, 32'd0);
        tick();
        ls_req_valid_i = 1'b0;
        check("s2_wdata", mem_req_wdata_o, 32'h1234_5678);
        check("s2_be", {28'd0, mem_req_be_o}, 32'h3);
        serve(32'h0000_0040, 1'b1, 32'hFFFF_FFFF);
        #1;
        check("s2_if_next", {31'd0, if_req_ready_o}, 32'd1);
        push(OWN_IF, 32'hCAFE_F00D);
        tick();
        if_req_valid_i = 1'b0;
        serve(32'h0000_0010, 1'b0, 32'hCAFE_F00D);

        // Starvation: ls held high with fetch pending
        ls_req_valid_i = 1'b1;
        ls_req_we_i    = 1'b0;
        ls_req_addr_i  = 32'h0000_0080;
        ls_req_be_i    = 4'hF;
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h0000_0200;
        for (int g = 0; g < 6; g++) begin
            logic fetch_turn;
            fetch_turn = (g == 4);
            #1;
            check($sformatf("s3_if_ready_%0d", g), {31'd0, if_req_ready_o}, {31'd0, fetch_turn});
            check($sformatf("s3_ls_ready_%0d", g), {31'd0, ls_req_ready_o}, {31'd0, !fetch_turn});
            push(fetch_turn ? OWN_IF : OWN_LS, 32'h1000 + g);
            tick();
            serve(fetch_turn ? 32'h0000_0200 : 32'h0000_0080, 1'b0, 32'h1000 + g);
        end
        ls_req_valid_i = 1'b0;
        if_req_valid_i = 1'b0;
        tick();

        // Memory stalls 5 cycles in ISSUE with a stray response mid-stall
        ls_req_valid_i = 1'b1;
        ls_req_we_i    = 1'b1;
        ls_req_addr_i  = 32'h0000_0300;
        ls_req_wdata_i = 32'h0000_AA55;
        ls_req_be_i    = 4'b1100;
        #1;
        check("s4_ls_ready", {31'd0, ls_req_ready_o}, 32'd1);
        push(OWN_LS, 32'd0);
        tick();
        ls_req_valid_i = 1'b0;
        if_req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("s4_stall_valid", {31'd0, mem_req_valid_o}, 32'd1);
            check("s4_stall_addr", mem_req_addr_o, 32'h0000_0300);
            check("s4_stall_wdata", mem_req_wdata_o, 32'h0000_AA55);
            check("s4_stall_be_we", {27'd0, mem_req_be_o, mem_req_we_o}, {27'd0, 4'b1100, 1'b1});
            check("s4_stall_ready", {30'd0, if_req_ready_o, ls_req_ready_o}, 32'd0);
            mem_rsp_valid_i = (i == 2);
            mem_rsp_data_i  = 32'h0000_0BAD;
            tick();
        end
        mem_rsp_valid_i = 1'b0;
        if_req_valid_i  = 1'b0;
        serve(32'h0000_0300, 1'b1, 32'h5555_5555);
        #1;
        check("s4_no_grant", {31'd0, if_req_ready_o}, 32'd0);
        tick();
        check("s4_idle_valid", {31'd0, mem_req_valid_o}, 32'd0);

        // Reset in WAIT drops the transaction
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h0000_0500;
        #1;
        check("s5_if_ready", {31'd0, if_req_ready_o}, 32'd1);
        tick();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        #1;
        check("s5_in_wait", {31'd0, mem_req_valid_o}, 32'd0);
        rstn_i = 1'b0;
        #1;
        check("s5_rst_valid", {31'd0, mem_req_valid_o}, 32'd0);
        check("s5_rst_addr", mem_req_addr_o, 32'd0);
        check("s5_rst_wdata", mem_req_wdata_o, 32'd0);
        check("s5_rst_be_we", {27'd0, mem_req_be_o, mem_req_we_o}, 32'd0);
        check("s5_rst_rsp", {30'd0, if_rsp_valid_o, ls_rsp_valid_o}, 32'd0);
        check("s5_rst_if_data", if_rsp_data_o, 32'd0);
        check("s5_rst_ls_data", ls_rsp_data_o, 32'd0);
        check("s5_rst_ready", {30'd0, if_req_ready_o, ls_req_ready_o}, 32'd0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h7777_7777;
        tick();
        tick();
        rstn_i = 1'b1;
        tick();
        mem_rsp_valid_i = 1'b0;
        check("s5_late_rsp", {30'd0, if_rsp_valid_o, ls_rsp_valid_o}, 32'd0);
        tick();
        check("s5_late_rsp2", {30'd0, if_rsp_valid_o, ls_rsp_valid_o}, 32'd0);
        check("s5_idle_valid", {31'd0, mem_req_valid_o}, 32'd0);

        // Normal service resumes after reset
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h0000_0600;
        #1;
        check("s6_if_ready", {31'd0, if_req_ready_o}, 32'd1);
        push(OWN_IF, 32'hABCD_0123);
        tick();
        if_req_valid_i = 1'b0;
        serve(32'h0000_0600, 1'b0, 32'hABCD_0123);
        #1;
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arbiter
